// File: rtl/gcd_lcm_unit.sv
// Iterative GCD (subtractive or binary/Stein) followed by a restoring divider
// and a multiply that produces the LCM from the same operand pair.
module gcd_lcm_unit #(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    input  logic           MODE,
    input  logic           START,
    output logic           BUSY,
    output logic           DONE,
    output logic           ERROR,
    output logic [W-1:0]   Y,
    output logic [2*W-1:0] LCM,
    output logic [CW-1:0]  ITER
);

    localparam int KW = $clog2(W);
    localparam int DW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, CALC, DIV, FINISH} state_t;

    state_t         state, state_next;
    logic [W-1:0]   a, b, a0, b0, g;
    logic           mode;
    logic [KW-1:0]  k;
    logic [CW-1:0]  iter;
    logic [W-1:0]   dvd, rem, quo;
    logic [DW-1:0]  dcnt;

    logic [W-1:0]   a_nxt, b_nxt, g_nxt;
    logic [KW-1:0]  k_nxt;
    logic [CW-1:0]  iter_inc;
    logic           zero_op, calc_eq, div_last;
    logic [W:0]     rem_sh;
    logic           ge;
    logic [W-1:0]   rem_nxt, q_nxt;
    logic [2*W-1:0] lcm_prod;

    assign BUSY     = (state != IDLE);
    assign DONE     = (state == FINISH);
    assign zero_op  = (A == '0) || (B == '0);
    assign calc_eq  = (a == b);
    assign div_last = (dcnt == DW'(W - 1));
    assign iter_inc = (&iter) ? iter : iter + CW'(1);

    // Restoring divider step: shift in the next dividend bit, subtract if it fits
    assign rem_sh   = {rem, dvd[W-1]};
    assign ge       = (rem_sh >= {1'b0, g});
    assign rem_nxt  = ge ? W'(rem_sh - {1'b0, g}) : rem_sh[W-1:0];
    assign q_nxt    = W'({quo, ge});
    assign lcm_prod = {{W{1'b0}}, q_nxt} * {{W{1'b0}}, b0};

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (START) state_next = zero_op ? FINISH : CALC;
            CALC:    if (calc_eq) state_next = DIV;
            DIV:     if (div_last) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        a_nxt = a;
        b_nxt = b;
        g_nxt = g;
        k_nxt = k;
        if (calc_eq) begin
            g_nxt = mode ? (a << k) : a;
        end else if (!mode) begin
            if (a > b) a_nxt = a - b;
            else       b_nxt = b - a;
        end else if (!a[0] && !b[0]) begin
            a_nxt = a >> 1;
            b_nxt = b >> 1;
            k_nxt = k + KW'(1);
        end else if (!a[0]) begin
            a_nxt = a >> 1;
        end else if (!b[0]) begin
            b_nxt = b >> 1;
        end else if (a > b) begin
            a_nxt = (a - b) >> 1;
        end else begin
            b_nxt = (b - a) >> 1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a     <= '0;
            b     <= '0;
            a0    <= '0;
            b0    <= '0;
            g     <= '0;
            mode  <= 1'b0;
            k     <= '0;
            iter  <= '0;
            dvd   <= '0;
            rem   <= '0;
            quo   <= '0;
            dcnt  <= '0;
            Y     <= '0;
            LCM   <= '0;
            ERROR <= 1'b0;
            ITER  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        a    <= A;
                        b    <= B;
                        a0   <= A;
                        b0   <= B;
                        mode <= MODE;
                        k    <= '0;
                        iter <= '0;
                        if (zero_op) begin
                            Y     <= '0;
                            LCM   <= '0;
                            ERROR <= 1'b1;
                            ITER  <= '0;
                        end
                    end
                end
                CALC: begin
                    iter <= iter_inc;
                    a    <= a_nxt;
                    b    <= b_nxt;
                    g    <= g_nxt;
                    k    <= k_nxt;
                    if (calc_eq) begin
                        dvd  <= a0;
                        rem  <= '0;
                        quo  <= '0;
                        dcnt <= '0;
                    end
                end
                DIV: begin
                    dvd  <= dvd << 1;
                    rem  <= rem_nxt;
                    quo  <= q_nxt;
                    dcnt <= dcnt + DW'(1);
                    // Final quotient bit is folded straight into the product
                    if (div_last) begin
                        Y     <= g;
                        LCM   <= lcm_prod;
                        ERROR <= 1'b0;
                        ITER  <= iter;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_lcm_unit.sv
// Bench for gcd_lcm_unit: vector table through a scoreboard on a W=8 instance,
// hand sequences for control corners, and a W=16 instance for wide operands.
module tb_gcd_lcm_unit;

    typedef struct {
        logic        mode;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  y;
        logic [15:0] lcm;
        logic        err;
        int          iter;
        int          cyc;
    } vec_t;

    typedef struct {
        vec_t v;
        int   start_cyc;
    } exp_t;

    logic        clk, rst;
    logic [7:0]  a8, b8, y8, iter8;
    logic        mode8, start8, busy8, done8, err8;
    logic [15:0] lcm8;
    logic [15:0] a16, b16, y16;
    logic        mode16, start16, busy16, done16, err16;
    logic [31:0] lcm16;
    logic [7:0]  iter16;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[14];

    gcd_lcm_unit #(.W(8), .CW(8)) u8 (
        .CLK(clk), .RST(rst), .A(a8), .B(b8), .MODE(mode8), .START(start8),
        .BUSY(busy8), .DONE(done8), .ERROR(err8), .Y(y8), .LCM(lcm8), .ITER(iter8)
    );

    gcd_lcm_unit #(.W(16), .CW(8)) u16 (
        .CLK(clk), .RST(rst), .A(a16), .B(b16), .MODE(mode16), .START(start16),
        .BUSY(busy16), .DONE(done16), .ERROR(err16), .Y(y16), .LCM(lcm16), .ITER(iter16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Scoreboard consumer: every DONE pulse must match the oldest pending request
    always @(negedge clk) begin
        if (done8) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation");
            end else begin
                mon_e = sb.pop_front();
                chk("y",          64'(y8),    64'(mon_e.v.y));
                chk("lcm",        64'(lcm8),  64'(mon_e.v.lcm));
                chk("error",      64'(err8),  64'(mon_e.v.err));
                chk("iter",       64'(iter8), 64'(mon_e.v.iter));
                chk("done_cycle", 64'(cyc - mon_e.start_cyc - 1), 64'(mon_e.v.cyc));
            end
        end
    end

    task automatic issue(input vec_t v);
        exp_t e;
        @(negedge clk);
        mode8  = v.mode;
        a8     = v.a;
        b8     = v.b;
        start8 = 1'b1;
        e.v = v;
        e.start_cyc = cyc;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(sb.size() == 0 && !busy8) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL timeout: got busy=%0d pending=%0d expected idle", busy8, sb.size());
            sb.delete();
        end
    endtask

    task automatic run16(input logic m, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ey, input logic [31:0] el, input int eiter);
        int n;
        @(negedge clk);
        mode16  = m;
        a16     = a;
        b16     = b;
        start16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        n = 0;
        while (!done16 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL w16_timeout: got done=0 expected done within 3000 cycles");
        end else begin
            chk("w16_y",     64'(y16),   64'(ey));
            chk("w16_lcm",   64'(lcm16), 64'(el));
            chk("w16_error", 64'(err16), 64'd0);
            if (eiter >= 0) chk("w16_iter", 64'(iter16), 64'(eiter));
        end
        n = 0;
        while (busy16 && n < 10) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        vec_t v;
        int   n;
        exp_t e;

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; mode8 = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; mode16 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  64'(busy8), 64'd0);
        chk("rst_done",  64'(done8), 64'd0);
        chk("rst_error", 64'(err8),  64'd0);
        chk("rst_y",     64'(y8),    64'd0);
        chk("rst_lcm",   64'(lcm8),  64'd0);
        chk("rst_iter",  64'(iter8), 64'd0);
        rst = 1'b0;

        //             mode  a       b       y        lcm        err   iter cyc
        tbl[0]  = '{1'b0, 8'd12,  8'd8,   8'd4,    16'd24,    1'b0, 3,   11};
        tbl[1]  = '{1'b1, 8'd48,  8'd18,  8'd6,    16'd144,   1'b0, 6,   14};
        tbl[2]  = '{1'b0, 8'd0,   8'd5,   8'd0,    16'd0,     1'b1, 0,   0};
        tbl[3]  = '{1'b1, 8'd0,   8'd5,   8'd0,    16'd0,     1'b1, 0,   0};
        tbl[4]  = '{1'b0, 8'd9,   8'd6,   8'd3,    16'd18,    1'b0, 3,   11};
        tbl[5]  = '{1'b0, 8'd255, 8'd255, 8'd255,  16'd255,   1'b0, 1,   9};
        tbl[6]  = '{1'b0, 8'd255, 8'd1,   8'd1,    16'd255,   1'b0, 255, 263};
        tbl[7]  = '{1'b1, 8'd5,   8'd0,   8'd0,    16'd0,     1'b1, 0,   0};
        tbl[8]  = '{1'b1, 8'd7,   8'd1,   8'd1,    16'd7,     1'b0, 3,   11};
        tbl[9]  = '{1'b1, 8'd1,   8'd200, 8'd1,    16'd200,   1'b0, 8,   16};
        tbl[10] = '{1'b1, 8'd128, 8'd64,  8'd64,   16'd128,   1'b0, 8,   16};
        tbl[11] = '{1'b1, 8'd255, 8'd255, 8'd255,  16'd255,   1'b0, 1,   9};
        tbl[12] = '{1'b0, 8'd255, 8'd254, 8'd1,    16'd64770, 1'b0, 255, 263};
        tbl[13] = '{1'b0, 8'd200, 8'd150, 8'd50,   16'd600,   1'b0, 4,   12};

        for (int i = 0; i < 14; i++) begin
            issue(tbl[i]);
            wait_idle(400);
        end

        // Results hold while idle
        repeat (5) @(negedge clk);
        chk("hold_y",   64'(y8),   64'd50);
        chk("hold_lcm", 64'(lcm8), 64'd600);

        // START during FINISH is ignored, START in the next IDLE cycle is taken
        issue(tbl[0]);
        n = 0;
        while (!done8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        mode8 = 1'b0; a8 = 8'd9; b8 = 8'd6; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        e.v = tbl[4];
        e.start_cyc = cyc;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        wait_idle(100);

        // START pulses during CALC and DIV leave the running operation alone
        issue(tbl[12]);
        repeat (3) @(negedge clk);
        a8 = 8'd0; b8 = 8'd9; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (255) @(negedge clk);
        a8 = 8'd12; b8 = 8'd8; mode8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_idle(400);

        // Reset in the middle of DIV aborts with no DONE
        issue(tbl[13]);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy",  64'(busy8), 64'd0);
        chk("abort_done",  64'(done8), 64'd0);
        chk("abort_y",     64'(y8),    64'd0);
        chk("abort_lcm",   64'(lcm8),  64'd0);
        chk("abort_error", 64'(err8),  64'd0);
        chk("abort_iter",  64'(iter8), 64'd0);
        sb.delete();
        rst = 1'b0;
        repeat (20) @(negedge clk);
        v = tbl[4];
        issue(v);
        wait_idle(100);

        run16(1'b1, 16'd65535, 16'd1,     16'd1,     32'd65535,  16);
        run16(1'b1, 16'd40000, 16'd30000, 16'd10000, 32'd120000, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gcd_lcm_unit.md
GCD_LCM_UNIT -- requirements
Module: gcd_lcm_unit

Interface
REQ-001 Parameter W, default 8: operand width in bits, W >= 2.
REQ-002 Parameter CW, default 8: width of iteration counter ITER.
REQ-003 CLK  input  1: single clock; all state updates on rising edge.
REQ-004 RST  input  1: reset, synchronous and active-high.
REQ-005 A  input  W: first operand, sampled only on START acceptance.
REQ-006 B  input  W: second operand, sampled only on START acceptance.
REQ-007 MODE  input  1: 0 = subtractive GCD, 1 = binary (Stein) GCD; sampled only on START acceptance.
REQ-008 START  input  1: request; accepted only when BUSY=0.
REQ-009 BUSY  output  1: high whenever state is not IDLE.
REQ-010 DONE  output  1: one-cycle pulse; result outputs are valid in that cycle.
REQ-011 ERROR  output  1: operand was zero in the completed operation.
REQ-012 Y  output  W: GCD result.
REQ-013 LCM  output  2W: LCM result.
REQ-014 ITER  output  CW: CALC cycles used by the completed operation, saturating at 2^CW-1.

Function
REQ-015 FSM states SHALL be IDLE, CALC, DIV and FINISH; every state is registered.
REQ-016 In IDLE with START=1, the block SHALL latch A, B and MODE into internal a, b, a0, b0 and mode, clear shift count k and the iteration counter, and go to CALC. If A=0 or B=0 it SHALL go straight to FINISH with the error flag set instead.
REQ-017 START while BUSY=1 SHALL be ignored; latched operands are unaffected.
REQ-018 CALC, each cycle, iteration counter +1 (saturating), then the first matching rule SHALL apply. MODE 0: a==b -> g=a, go DIV; a>b -> a=a-b; else b=b-a.
REQ-019 CALC MODE 1, first matching rule: a==b -> g=a<<k, go DIV; both even -> a>>=1, b>>=1, k+=1; a even -> a>>=1; b even -> b>>=1; a>b -> a=(a-b)>>1; else b=(b-a)>>1.
REQ-020 k SHALL be wide enough to hold values up to W-1, and g SHALL never exceed 2^W-1.
REQ-021 DIV SHALL compute q = a0 / g with a restoring divider, one quotient bit per cycle, exactly W cycles; remainder is discarded and is zero by construction.
REQ-022 LCM SHALL equal q * b0, a full 2W-bit product with no truncation.
REQ-023 Timing: cycle n is the cycle following the n-th rising edge after the edge that samples START (edge 0).
REQ-024 Normal-path timing: CALC occupies cycles 0..ITER-1, DIV occupies cycles ITER..ITER+W-1, FINISH is cycle ITER+W.
REQ-025 Error-path timing: FINISH is cycle 0.
REQ-026 On entry to FINISH, Y, LCM, ERROR and ITER SHALL be registered. Error path: Y=0, LCM=0, ERROR=1, ITER=0. Otherwise: Y=g, LCM=q*b0, ERROR=0.
REQ-027 DONE SHALL be high exactly in the FINISH cycle; FINISH SHALL return to IDLE unconditionally.
REQ-028 START in the FINISH cycle SHALL be ignored; START in the following IDLE cycle SHALL be accepted.
REQ-029 Y, LCM, ERROR and ITER SHALL hold their values until the next FINISH entry.
REQ-030 A==B nonzero SHALL give Y=A, LCM=A, ITER=1.
REQ-031 Operand 1 SHALL give Y=1 and LCM equal to the other operand.
REQ-032 MODE 0 worst case (A=2^W-1, B=1) SHALL take 2^W-1 CALC cycles; ITER saturates if CW is too small, and the GCD result is unaffected.

Reset
REQ-033 RST=1 at a rising edge SHALL force IDLE.
REQ-034 RST=1 SHALL clear BUSY, DONE, ERROR, Y, LCM, ITER and all internal registers to 0.
REQ-035 RST SHALL take priority over START and over any in-progress operation; an aborted operation produces no DONE pulse.

Verification
REQ-036 W=8, MODE=0, A=12, B=8 -> ITER=3, DONE in cycle 11, Y=4, LCM=24, ERROR=0.
REQ-037 W=8, MODE=1, A=48, B=18 -> ITER=6, DONE in cycle 14, Y=6, LCM=144.
REQ-038 W=8, A=0, B=5, either MODE -> DONE in cycle 0, ERROR=1, Y=0, LCM=0, ITER=0. Then A=9, B=6 issued in the next IDLE cycle -> ERROR=0, Y=3, LCM=18.
REQ-039 W=8, MODE=0, A=B=255 -> ITER=1, Y=255, LCM=255. Then A=255, B=1 -> ITER=255, Y=1, LCM=255.
REQ-040 W=16, MODE=1, A=65535, B=1 -> Y=1, LCM=65535. A=40000, B=30000 -> Y=10000, LCM=120000.
REQ-041 Control checks: START pulses during CALC and DIV leave results unchanged. RST asserted mid-DIV -> next cycle BUSY=0 and all outputs 0, no DONE pulse. A new START then completes correctly.
